arb_barramento: RTL and testbench
=================================

ARB_BARRAMENTO -- requirements
Module: arb_barramento

Interface
REQ-001 Parameter DW, 8, data width of every requester and of the shared bus.
REQ-002 Parameter TIMEOUT, 16, max cycles in GRANT without bus_read before abort; legal range 2..255.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 req_valid  input  4  per-requester request; bit i asserted by requester i holding a word.
REQ-006 req_data  input  4*DW  requester i word on bits [i*DW+DW-1 : i*DW].
REQ-007 req_ack  output  4  one-cycle pulse on bit i when requester i's word is consumed.
REQ-008 grant  output  4  one-hot owner of the bus; all zero when idle.
REQ-009 bus_valid  output  1  data_valid toward the bus consumer.
REQ-010 bus_data  output  DW  data toward the bus consumer.
REQ-011 bus_read  input  1  data_read from the bus consumer.
REQ-012 timeout_err  output  1  one-cycle pulse when a grant is aborted by TIMEOUT.
REQ-013 xfer_count  output  16  count of completed transfers, wraps 16'hFFFF -> 0.

Function
REQ-014 FSM states SHALL be IDLE, GRANT, HOLD, RELEASE; all outputs registered.
REQ-015 IDLE: if any req_valid high, select winner by round robin, latch its req_data into bus_data, set grant one-hot, set bus_valid=1, clear timer, go GRANT next cycle; else stay.
REQ-016 Round robin: search starts at (last_winner+1) mod 4, ascending with wrap; last_winner updates on every grant, including aborted ones.
REQ-017 req_valid and req_data SHALL be sampled only in IDLE; changes during GRANT/HOLD/RELEASE ignored; bus_data stable for entire grant.
REQ-018 GRANT: bus_read=1 -> HOLD; else timer increments; timer reaching TIMEOUT-1 with bus_read=0 -> bus_valid=0, grant=0, timeout_err pulse, no req_ack, go RELEASE.
REQ-019 HOLD: bus_valid stays 1 while bus_read=1; on first cycle bus_read=0 -> bus_valid=0, grant=0, req_ack[winner] pulse, xfer_count+1, go RELEASE.
REQ-020 RELEASE: bus_valid=0 for exactly one cycle, then IDLE; guarantees consumer sees data_valid low before next grant.
REQ-021 Timing, request first seen in IDLE at edge E0: bus_valid=1 after E0; with consumer asserting bus_read two cycles, bus_valid=0 and req_ack after E4, earliest next bus_valid after E6.
REQ-022 A requester still asserting req_valid after its ack SHALL be treated as a new request, subject to rotation.
REQ-023 Single requester continuously requesting SHALL be granted back-to-back, one grant per full IDLE-GRANT-HOLD-RELEASE cycle.
REQ-024 bus_read=1 while in IDLE or RELEASE SHALL be ignored (no state change, no ack).
REQ-025 At most one bit of grant and of req_ack high in any cycle; req_ack and timeout_err never high together.

Reset
REQ-026 reset=1 at a rising edge forces state IDLE, grant=0, bus_valid=0, bus_data=0, req_ack=0, timeout_err=0, xfer_count=0, timer=0, last_winner=3 (requester 0 highest priority first).
REQ-027 Reset mid-transfer SHALL abort without req_ack and without counting; reset has priority over all other inputs.

Verification
REQ-028 Single: req_valid=4'b0100, req_data[23:16]=8'hA5, consumer model -> grant=4'b0100, bus_data=8'hA5, one req_ack[2] pulse, xfer_count=1.
REQ-029 Contention: req_valid=4'b1111 held, words 8'h10..8'h13 -> grant order 0,1,2,3,0, xfer_count=5 after five transfers.
REQ-030 Timeout: req_valid=4'b0001, bus_read tied 0 -> bus_valid high exactly TIMEOUT cycles, timeout_err one pulse, req_ack stays 0, next grant starts at requester 1.
REQ-031 Data stability: req_data changed during HOLD -> bus_data keeps latched value until bus_valid falls.
REQ-032 Reset mid-HOLD: reset asserted with bus_read=1 -> next cycle all outputs zero, no req_ack, xfer_count=0.
REQ-033 Wrap: preload via 65536 transfers (or forced count 16'hFFFF) plus one transfer -> xfer_count=16'h0000.

Source files
------------

// File: rtl/arb_barramento.sv
// Four-requester round-robin bus arbiter with a registered word handoff toward a single consumer.
// A grant is aborted if the consumer does not read within TIMEOUT cycles.
module arb_barramento #(
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      req_valid,
    input  logic [4*DW-1:0] req_data,
    output logic [3:0]      req_ack,
    output logic [3:0]      grant,
    output logic            bus_valid,
    output logic [DW-1:0]   bus_data,
    input  logic            bus_read,
    output logic            timeout_err,
    output logic [15:0]     xfer_count
);
    localparam int unsigned NREQ = 4;
    localparam int unsigned TW   = 8;
    localparam int unsigned CW   = 16;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    logic [1:0]    state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [1:0]    last_winner, last_winner_nxt;
    logic [3:0]    grant_nxt, req_ack_nxt;
    logic          bus_valid_nxt, timeout_err_nxt;
    logic [DW-1:0] bus_data_nxt;
    logic [CW-1:0] xfer_count_nxt;

    logic          found_c;
    logic [1:0]    pick_c;
    logic [DW-1:0] word_c;

    // Round-robin search starting just after the previous winner
    always_comb begin
        found_c = 1'b0;
        pick_c  = last_winner;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            if (!found_c && req_valid[last_winner + 2'(i)]) begin
                found_c = 1'b1;
                pick_c  = last_winner + 2'(i);
            end
        end
        word_c = req_data[32'(pick_c) * DW +: DW];
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt       = state;
        timer_nxt       = timer;
        last_winner_nxt = last_winner;
        grant_nxt       = grant;
        bus_valid_nxt   = bus_valid;
        bus_data_nxt    = bus_data;
        req_ack_nxt     = '0;
        timeout_err_nxt = 1'b0;
        xfer_count_nxt  = xfer_count;
        case (state)
            IDLE: begin
                if (found_c) begin
                    state_nxt       = GRANT;
                    grant_nxt       = 4'(1) << pick_c;
                    bus_valid_nxt   = 1'b1;
                    bus_data_nxt    = word_c;
                    timer_nxt       = '0;
                    last_winner_nxt = pick_c;
                end
            end
            GRANT: begin
                if (bus_read) begin
                    state_nxt = HOLD;
                end else if (timer == TIMER_LAST) begin
                    state_nxt       = RELEASE;
                    bus_valid_nxt   = 1'b0;
                    grant_nxt       = '0;
                    timeout_err_nxt = 1'b1;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            HOLD: begin
                if (!bus_read) begin
                    state_nxt      = RELEASE;
                    bus_valid_nxt  = 1'b0;
                    grant_nxt      = '0;
                    req_ack_nxt    = grant;
                    xfer_count_nxt = xfer_count + CW'(1);
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            last_winner <= 2'd3;
            grant       <= '0;
            bus_valid   <= 1'b0;
            bus_data    <= '0;
            req_ack     <= '0;
            timeout_err <= 1'b0;
            xfer_count  <= '0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            last_winner <= last_winner_nxt;
            grant       <= grant_nxt;
            bus_valid   <= bus_valid_nxt;
            bus_data    <= bus_data_nxt;
            req_ack     <= req_ack_nxt;
            timeout_err <= timeout_err_nxt;
            xfer_count  <= xfer_count_nxt;
        end
    end
endmodule

// File: tb/tb_arb_barramento.sv
// Scoreboard bench for arb_barramento: stimulus pushes expected grants, a negedge monitor checks them.
module tb_arb_barramento;
    localparam int DW      = 8;
    localparam int TIMEOUT = 16;

    logic            clk;
    logic            reset;
    logic [3:0]      req_valid;
    logic [4*DW-1:0] req_data;
    logic [3:0]      req_ack;
    logic [3:0]      grant;
    logic            bus_valid;
    logic [DW-1:0]   bus_data;
    logic            bus_read;
    logic            timeout_err;
    logic [15:0]     xfer_count;

    arb_barramento #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ack    (req_ack),
        .grant      (grant),
        .bus_valid  (bus_valid),
        .bus_data   (bus_data),
        .bus_read   (bus_read),
        .timeout_err(timeout_err),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          w;
        logic [7:0]  data;
        bit          tmo;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int stim_fails = 0;
    int model_last;
    int preload_seq = 0;

    // ---------------- monitor / scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    logic        prev_valid = 1'b0;
    bit          active = 1'b0;
    exp_t        cur;
    int          vcount = 0;
    logic [15:0] model_count = '0;
    int          preload_seen = 0;

    always @(negedge clk) begin
        if (preload_seen != preload_seq) begin
            model_count  = 16'hFFFF;
            preload_seen = preload_seq;
        end
        if (reset) begin
            check("reset_outputs", {11'd0, grant, bus_valid, bus_data, req_ack, timeout_err},
                  32'd0);
            check("reset_count", {16'd0, xfer_count}, 32'd0);
            prev_valid  = 1'b0;
            active      = 1'b0;
            model_count = '0;
        end else begin
            if (bus_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_grant: got grant %b with no request expected", grant);
                    active = 1'b0;
                end else begin
                    cur    = exp_q.pop_front();
                    active = 1'b1;
                    vcount = 1;
                    check("grant_onehot", {28'd0, grant}, 32'(1) << cur.w);
                    check("bus_data_latch", {24'd0, bus_data}, {24'd0, cur.data});
                end
            end else if (bus_valid) begin
                vcount++;
                if (active) begin
                    check("bus_data_stable", {24'd0, bus_data}, {24'd0, cur.data});
                    check("grant_stable", {28'd0, grant}, 32'(1) << cur.w);
                end
            end else begin
                check("grant_idle", {28'd0, grant}, 32'd0);
            end

            if (!bus_valid && prev_valid && active) begin
                check("req_ack", {28'd0, req_ack}, cur.tmo ? 32'd0 : (32'(1) << cur.w));
                check("timeout_err", {31'd0, timeout_err}, {31'd0, cur.tmo});
                if (!cur.tmo) model_count = model_count + 16'd1;
                check("xfer_count", {16'd0, xfer_count}, {16'd0, model_count});
                if (cur.tmo) check("valid_cycles", 32'(vcount), 32'(TIMEOUT));
                active = 1'b0;
            end else begin
                check("ack_quiet", {27'd0, req_ack, timeout_err}, 32'd0);
            end
            prev_valid = bus_valid;
        end
    end

    // ---------------- reference model and stimulus ----------------
    function automatic int rr_pick(input logic [3:0] mask, input int last);
        for (int o = 1; o <= 4; o++) begin
            if (mask[(last + o) % 4]) return (last + o) % 4;
        end
        return -1;
    endfunction

    task automatic wait_level(input logic lvl, input int budget, input string what);
        int n = 0;
        while (bus_valid !== lvl && n < budget) begin
            @(negedge clk);
            if (lvl) bus_read = 1'b0;
            n++;
        end
        if (bus_valid !== lvl) begin
            stim_fails++;
            $display("FAIL %s: bus_valid stuck at %b after %0d cycles", what, bus_valid, budget);
        end
    endtask

    task automatic push_exp(input logic [3:0] mask, input logic [31:0] words, input bit tmo);
        exp_t e;
        logic [31:0] wv;
        e.w   = rr_pick(mask, model_last);
        wv    = words >> (8 * e.w);
        e.data = wv[7:0];
        e.tmo = tmo;
        exp_q.push_back(e);
        model_last = e.w;
    endtask

    task automatic txn(input logic [3:0] mask, input logic [31:0] words, input bit tmo,
                       input int d, input int k);
        push_exp(mask, words, tmo);
        req_valid = mask;
        req_data  = words;
        wait_level(1'b1, 20, "grant_wait");
        // Inputs move while granted; the DUT must ignore them
        req_data  = $urandom();
        req_valid = 4'($urandom());
        if (!tmo) begin
            repeat (d) @(negedge clk);
            bus_read = 1'b1;
            repeat (k) @(negedge clk);
            bus_read = 1'b0;
        end
        wait_level(1'b0, d + k + TIMEOUT + 10, "release_wait");
        req_valid = '0;
        bus_read  = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_gap(input int n);
        req_valid = '0;
        repeat (n) begin
            @(negedge clk);
            bus_read = 1'($urandom_range(0, 1));
        end
        bus_read = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        model_last = 3;
    endtask

    task automatic reset_mid_hold();
        push_exp(4'b0010, 32'h0000_5A00, 1'b0);
        req_valid = 4'b0010;
        req_data  = 32'h0000_5A00;
        wait_level(1'b1, 20, "grant_wait_rst");
        bus_read = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        bus_read   = 1'b0;
        req_valid  = '0;
        model_last = 3;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        bus_read   = 1'b0;
        model_last = 3;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        txn(4'b0100, 32'h00A5_0000, 1'b0, 1, 2);
        idle_gap(3);

        do_reset();
        repeat (5) txn(4'b1111, 32'h1312_1110, 1'b0, 0, 1);

        txn(4'b0001, 32'h0000_00C3, 1'b1, 0, 0);
        txn(4'b1111, 32'h1312_1110, 1'b0, TIMEOUT - 1, 1);
        idle_gap(2);

        reset_mid_hold();
        idle_gap(2);

        for (int t = 0; t < 80; t++) begin
            txn(4'($urandom_range(1, 15)), $urandom(), ($urandom_range(0, 5) == 0),
                $urandom_range(0, TIMEOUT - 1), $urandom_range(1, 4));
            if ($urandom_range(0, 1) == 1) idle_gap($urandom_range(1, 4));
        end

        idle_gap(3);
        force dut.xfer_count = 16'hFFFF;
        preload_seq++;
        @(negedge clk);
        release dut.xfer_count;
        txn(4'b1000, 32'h7700_0000, 1'b0, 0, 2);
        idle_gap(4);

        if (exp_q.size() != 0) begin
            stim_fails++;
            $display("FAIL pending_grants: %0d expected grants never seen", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks + stim_fails);
        $finish;
    end
endmodule
